// File: rtl/serial_or_reducer.sv
// Bit-serial OR-reduction: scans a WIDTH-bit word LSB-first through one mux-based
// 2-input OR, reporting the reduction and the lowest set-bit index.

module or_gate_using_mux (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ? 1'b1 : b;
endmodule

module serial_or_reducer #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_data,
  output logic [$clog2(WIDTH)-1:0] out_index
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             acc, acc_nxt, found;
  logic [CW-1:0]    cnt;
  logic             hit, last_bit;

  assign hit      = shreg[0] & ~found;
  assign last_bit = (cnt == LAST);

  or_gate_using_mux u_or (
    .a (acc),
    .b (shreg[0]),
    .y (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (last_bit || (EARLY_EXIT && hit)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // out_index is cleared on accept so an all-zero word reports index 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      acc       <= 1'b0;
      found     <= 1'b0;
      cnt       <= '0;
      out_index <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shreg     <= in_data;
          acc       <= 1'b0;
          found     <= 1'b0;
          cnt       <= '0;
          out_index <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          if (hit) begin
            out_index <= cnt;
            found     <= 1'b1;
          end
          shreg <= shreg >> 1;
          if (!last_bit) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
endmodule

// File: tb/tb_serial_or_reducer.sv
// Directed bench: dut0 scans full words, dut1 exits early on the first set bit.

module tb_serial_or_reducer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v0 = 1'b0, r0 = 1'b0, v1 = 1'b0, r1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       rdy0, ov0, od0, rdy1, ov1, od1;
  logic [2:0] oi0, oi1;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  bit         mon = 1'b0;
  int         acc_n = 0, res_n = 0;
  int         acc_t [4];
  logic       res_d [4];
  logic [2:0] res_i [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_or_reducer #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .out_valid(ov0), .out_ready(r0), .out_data(od0), .out_index(oi0));

  serial_or_reducer #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(ov1), .out_ready(r1), .out_data(od1), .out_index(oi1));

  always @(posedge clk) if (mon) begin
    if (v0 && rdy0 && acc_n < 4) begin acc_t[acc_n] = cyc; acc_n++; end
    if (ov0 && r0 && res_n < 4) begin res_d[res_n] = od0; res_i[res_n] = oi0; res_n++; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input int sel, input logic [7:0] d, input string tag);
    @(negedge clk);
    if (sel == 0) begin chk({tag, " in_ready"}, 32'(rdy0), 1); v0 = 1'b1; d0 = d; end
    else          begin chk({tag, " in_ready"}, 32'(rdy1), 1); v1 = 1'b1; d1 = d; end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0; d0 = 8'hA5; d1 = 8'hA5;
  endtask

  task automatic wait_out(input int sel, input int lat, input logic ed, input logic [2:0] ei,
                          input string tag);
    int n = 0;
    while (!(sel == 0 ? ov0 : ov1) && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " out_data"}, 32'(sel == 0 ? od0 : od1), 32'(ed));
    chk({tag, " out_index"}, 32'(sel == 0 ? oi0 : oi1), 32'(ei));
  endtask

  task automatic post_hs(input int sel, input string tag);
    @(posedge clk); #1;
    chk({tag, " valid drop"}, 32'(sel == 0 ? ov0 : ov1), 0);
    chk({tag, " ready back"}, 32'(sel == 0 ? rdy0 : rdy1), 1);
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    chk("rst out_valid", 32'({ov0, ov1}), 0);
    chk("rst out_data",  32'({od0, od1}), 0);
    chk("rst out_index", 32'({oi0, oi1}), 0);
    chk("rst in_ready",  32'({rdy0, rdy1}), 32'h3);

    r0 = 1'b1; r1 = 1'b1;
    accept(0, 8'h00, "t1"); wait_out(0, 8, 1'b0, 3'd0, "t1"); post_hs(0, "t1");
    accept(0, 8'h80, "t2"); wait_out(0, 8, 1'b1, 3'd7, "t2"); post_hs(0, "t2");
    accept(0, 8'h14, "t3a"); wait_out(0, 8, 1'b1, 3'd2, "t3a"); post_hs(0, "t3a");
    accept(1, 8'h14, "t3b"); wait_out(1, 3, 1'b1, 3'd2, "t3b"); post_hs(1, "t3b");
    accept(1, 8'h80, "t3c"); wait_out(1, 8, 1'b1, 3'd7, "t3c"); post_hs(1, "t3c");
    accept(1, 8'h00, "t3d"); wait_out(1, 8, 1'b0, 3'd0, "t3d"); post_hs(1, "t3d");

    // Backpressure in DONE
    r0 = 1'b0;
    accept(0, 8'h28, "t4"); wait_out(0, 8, 1'b1, 3'd3, "t4");
    repeat (5) begin
      @(posedge clk); #1;
      chk("t4 hold", 32'({ov0, od0, oi0, rdy0}), 32'b1_1_011_0);
    end
    @(negedge clk); r0 = 1'b1;
    post_hs(0, "t4");

    // Reset abort at cnt == 3
    accept(0, 8'hFF, "t5");
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    chk("t5 out_valid", 32'(ov0), 0);
    chk("t5 in_ready", 32'(rdy0), 1);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (ov0) seen = 1'b1; end
    chk("t5 no result", 32'(seen), 0);

    // Back-to-back with in_valid and out_ready high
    @(negedge clk); mon = 1'b1; v0 = 1'b1; d0 = 8'h01; r0 = 1'b1;
    for (int i = 0; i < 60 && res_n < 2; i++) begin
      @(negedge clk);
      if (acc_n == 1) d0 = 8'hFF;
      if (acc_n >= 2) v0 = 1'b0;
    end
    v0 = 1'b0; mon = 1'b0;
    chk("t6 accepts", 32'(acc_n), 2);
    chk("t6 results", 32'(res_n), 2);
    if (acc_n == 2) chk("t6 spacing", 32'(acc_t[1] - acc_t[0]), 10);
    if (res_n == 2) begin
      chk("t6 r0", 32'({res_d[0], res_i[0]}), 32'b1_000);
      chk("t6 r1", 32'({res_d[1], res_i[1]}), 32'b1_000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
